mc_control_fsm: RTL and testbench
=================================

// Module: mc_control_fsm
// PURPOSE
// Multi-cycle main controller upstream of the datapath. Decodes op/funct3/funct7b5 and sequences
// fetch/decode/execute/memory/writeback. Drives every datapath select/enable per cycle.
// Stalls on a mem_ready handshake, flags memory timeouts and counts retired instructions.
// PARAMETERS
// MEM_TIMEOUT  15  consecutive !mem_ready wait cycles before bus_err sets
// CNT_W         4  wait-counter width; must hold MEM_TIMEOUT
// RETIRE_W     32  retired-instruction counter width
// PORTS
// clk          in   1        clock, rising edge
// srst         in   1        asynchronous reset, active-low
// op           in   7        instr[6:0]
// funct3       in   3        instr[14:12]
// funct7b5     in   1        instr[30]
// zero         in   1        ALU zero flag
// mem_ready    in   1        memory completes current access this cycle
// pc_write     out  1        PC register enable
// adr_src      out  1        0: address=PC, 1: address=ALU-out register
// mem_w        out  1        data memory write enable
// ir_write     out  1        instruction/old-PC register enable
// result_src   out  2        00 ALU-out reg, 01 read data, 10 ALU result
// alu_src_a    out  2        00 PC, 01 old PC, 10 rs1
// alu_src_b    out  2        00 rs2, 01 imm_ext, 10 constant 4
// alu_control  out  3        000 add, 001 sub, 010 and, 011 or, 101 slt
// imm_src      out  2        00 I, 01 S, 10 B, 11 J (combinational from op)
// reg_w        out  1        register file write enable
// bus_err      out  1        sticky memory-timeout flag
// illegal_instr out 1        sticky illegal-opcode flag (0 unless macro defined)
// retire_cnt   out  RETIRE_W retired instructions, wraps to 0
// state_o      out  4        current state, for debug/verification
// BEHAVIOUR
// - Reset (async, srst=0): state=FETCH, counters/flags=0. Strobes pc_write/ir_write/mem_w/reg_w=0.
// - Moore outputs decoded from state. pc_write is qualified by mem_ready in FETCH and by zero in BEQ.
// - States and transitions:
//   FETCH: adr_src=0, a=00, b=10, add, result_src=10. On mem_ready: ir_write=1, pc_write=1, ->DECODE.
//     Without mem_ready, holds with strobes 0.
//   DECODE: a=01, b=01, add (branch target). op lw/sw->MEMADR, R->EXECR, I-ALU->EXECI, beq->BEQ, jal->JAL.
//   MEMADR: a=10, b=01, add. lw->MEMREAD, sw->MEMWRITE.
//   MEMREAD: adr_src=1, result_src=00; on mem_ready ->MEMWB.
//   MEMWB: result_src=01, reg_w=1, ->FETCH.
//   MEMWRITE: adr_src=1, mem_w=1 held until mem_ready, then ->FETCH.
//   EXECR: a=10, b=00, funct decode. EXECI: a=10, b=01, funct decode. Both ->ALUWB.
//   ALUWB: result_src=00, reg_w=1, ->FETCH.
//   BEQ: a=10, b=00, sub, result_src=00, pc_write=zero, ->FETCH.
//   JAL: a=01, b=10, add, result_src=00, pc_write=1, ->ALUWB.
// - Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
// - Funct decode: f3 000 -> sub if op[5]&funct7b5, else add; 010 slt; 110 or; 111 and; others add.
// - retire_cnt +1 on entering FETCH from MEMWB, ALUWB, BEQ, or MEMWRITE (on ready). Wraps modulo 2^RETIRE_W.
// - Wait counter: +1 per cycle with !mem_ready in FETCH/MEMREAD/MEMWRITE; clears on ready or state change.
//   At MEM_TIMEOUT, bus_err sets. FSM keeps waiting and bus_err stays set until reset.
// - mem_ready outside wait states is ignored. Reset mid-instruction aborts to FETCH; no write strobe escapes.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined: unknown op in DECODE -> TRAP (state_o=4'hF), all strobes 0, illegal_instr=1.
//   Held until reset.
// - Not defined: unknown op in DECODE -> FETCH (NOP). Not counted as retired. illegal_instr tied 0.
// TESTING
// - add (op 0110011, f3 000, f7b5 0), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB,FETCH; alu_control=000; retire_cnt 0->1.
// - sw, mem_ready low 3 cycles in MEMWRITE -> mem_w=1 for 4 cycles, adr_src=1; one retire.
// - beq, zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both retire after 3 cycles.
// - mem_ready held 0 in FETCH -> bus_err=1 after 15 cycles; ir_write/pc_write stay 0.
// - srst low during MEMWRITE -> same cycle mem_w=0, state_o=FETCH, retire_cnt=0.
// - op=7'h7F with ILLEGAL_TRAP_EN -> state_o=4'hF, illegal_instr=1; without it -> FETCH, no retire.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller: sequences fetch/decode/execute/memory/writeback and drives datapath selects.
// Optional ILLEGAL_TRAP_EN: unknown opcodes park the FSM in TRAP and set illegal_instr.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4,
  parameter int RETIRE_W    = 32
) (
  input  logic                clk,
  input  logic                srst,
  input  logic [6:0]          op,
  input  logic [2:0]          funct3,
  input  logic                funct7b5,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                adr_src,
  output logic                mem_w,
  output logic                ir_write,
  output logic [1:0]          result_src,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          alu_control,
  output logic [1:0]          imm_src,
  output logic                reg_w,
  output logic                bus_err,
  output logic                illegal_instr,
  output logic [RETIRE_W-1:0] retire_cnt,
  output logic [3:0]          state_o
);

  localparam logic [3:0] S_FETCH    = 4'h0;
  localparam logic [3:0] S_DECODE   = 4'h1;
  localparam logic [3:0] S_MEMADR   = 4'h2;
  localparam logic [3:0] S_MEMREAD  = 4'h3;
  localparam logic [3:0] S_MEMWB    = 4'h4;
  localparam logic [3:0] S_MEMWRITE = 4'h5;
  localparam logic [3:0] S_EXECR    = 4'h6;
  localparam logic [3:0] S_EXECI    = 4'h7;
  localparam logic [3:0] S_ALUWB    = 4'h8;
  localparam logic [3:0] S_BEQ      = 4'h9;
  localparam logic [3:0] S_JAL      = 4'hA;
  localparam logic [3:0] S_TRAP     = 4'hF;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  logic [3:0]       state, state_nx;
  logic [CNT_W-1:0] wait_cnt;
  logic             waiting, retire_ev;
  logic [2:0]       alu_fn;

  assign state_o = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nx = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_nx = S_MEMADR;
          OP_R:         state_nx = S_EXECR;
          OP_I:         state_nx = S_EXECI;
          OP_BEQ:       state_nx = S_BEQ;
          OP_JAL:       state_nx = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      state_nx = S_TRAP;
`else
          default:      state_nx = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_nx = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_nx = S_MEMWB;
      S_MEMWB:    state_nx = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_nx = S_FETCH;
      S_EXECR,
      S_EXECI:    state_nx = S_ALUWB;
      S_ALUWB:    state_nx = S_FETCH;
      S_BEQ:      state_nx = S_FETCH;
      S_JAL:      state_nx = S_ALUWB;
      S_TRAP:     state_nx = S_TRAP;
      default:    state_nx = S_FETCH;
    endcase
  end

  // Subtract only for R-type with funct7[5]; immediate forms never subtract.
  always_comb begin
    case (funct3)
      3'b000:  alu_fn = (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  alu_fn = 3'b101;
      3'b110:  alu_fn = 3'b011;
      3'b111:  alu_fn = 3'b010;
      default: alu_fn = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    pc_write    = 1'b0;
    adr_src     = 1'b0;
    mem_w       = 1'b0;
    ir_write    = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_control = 3'b000;
    reg_w       = 1'b0;
    case (state)
      // Strobes are gated by srst so nothing fires while reset is held.
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready & srst;
        pc_write   = mem_ready & srst;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_control = alu_fn;
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        alu_control = alu_fn;
      end
      S_ALUWB:    reg_w = 1'b1;
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_control = 3'b001;
        pc_write    = zero;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  assign waiting   = ((state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE)) && !mem_ready;
  assign retire_ev = (state == S_MEMWB) || (state == S_ALUWB) || (state == S_BEQ) ||
                     ((state == S_MEMWRITE) && mem_ready);

  always_ff @(posedge clk or negedge srst) begin
    if (!srst) begin
      state      <= S_FETCH;
      wait_cnt   <= '0;
      bus_err    <= 1'b0;
      retire_cnt <= '0;
    end else begin
      state <= state_nx;
      if (retire_ev) retire_cnt <= retire_cnt + 1'b1;
      // Counter saturates at the timeout; the FSM itself keeps waiting.
      if (waiting) begin
        if (wait_cnt != CNT_W'(MEM_TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
        if (wait_cnt >= CNT_W'(MEM_TIMEOUT - 1)) bus_err <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clk or negedge srst) begin
    if (!srst)                  illegal_instr <= 1'b0;
    else if (state_nx == S_TRAP) illegal_instr <= 1'b1;
  end
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed and random instruction flows against a phase-level model.
module tb_mc_control_fsm;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3, P_MEMWB = 4,
                 P_MEMWRITE = 5, P_EXECR = 6, P_EXECI = 7, P_ALUWB = 8, P_BEQ = 9,
                 P_JAL = 10, P_TRAP = 11;

  logic        clk = 1'b0;
  logic        srst;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5, zero, mem_ready;
  logic        pc_write, adr_src, mem_w, ir_write, reg_w, bus_err, illegal_instr;
  logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]  alu_control;
  logic [31:0] retire_cnt;
  logic [3:0]  state_o;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] modelRetire = '0;
  logic        modelBusErr = 1'b0;
  logic        modelIllegal = 1'b0;
  int          waitCnt = 0;

  mc_control_fsm dut (
    .clk(clk), .srst(srst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src), .mem_w(mem_w),
    .ir_write(ir_write), .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_control(alu_control), .imm_src(imm_src), .reg_w(reg_w), .bus_err(bus_err),
    .illegal_instr(illegal_instr), .retire_cnt(retire_cnt), .state_o(state_o)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] pack(input logic pc, input logic adr, input logic mw, input logic ir,
                                       input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                                       input logic [2:0] alu, input logic rw);
    return {pc, adr, mw, ir, rs, a, b, alu, rw};
  endfunction

  function automatic logic [2:0] expAlu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] expImm(input logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [13:0] expCtrl(input int phase, input logic rdy, input logic z,
                                          input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (phase)
      P_FETCH:    return pack(rdy, 1'b0, 1'b0, rdy, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
      P_DECODE:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0);
      P_MEMADR:   return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0);
      P_MEMREAD:  return pack(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
      P_MEMWB:    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1);
      P_MEMWRITE: return pack(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
      P_EXECR:    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, expAlu(o, f3, f7), 1'b0);
      P_EXECI:    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, expAlu(o, f3, f7), 1'b0);
      P_ALUWB:    return pack(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);
      P_BEQ:      return pack(z, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0);
      P_JAL:      return pack(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0);
      default:    return 14'h0;
    endcase
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Check every output for the current phase, then advance the wait/timeout model for this edge.
  task automatic checkOutput(input string tag, input int phase);
    logic [13:0] got;
    got = {pc_write, adr_src, mem_w, ir_write, result_src, alu_src_a, alu_src_b, alu_control, reg_w};
    checkEq({tag, "_ctrl"}, 32'(got), 32'(expCtrl(phase, mem_ready, zero, op, funct3, funct7b5)));
    checkEq({tag, "_imm"}, 32'(imm_src), 32'(expImm(op)));
    checkEq({tag, "_retire"}, retire_cnt, modelRetire);
    checkEq({tag, "_buserr"}, 32'(bus_err), 32'(modelBusErr));
    checkEq({tag, "_illegal"}, 32'(illegal_instr), 32'(modelIllegal));
    if (phase == P_FETCH) checkEq({tag, "_state"}, 32'(state_o), 32'h0);
    if (phase == P_TRAP)  checkEq({tag, "_state"}, 32'(state_o), 32'hF);
    if ((phase == P_FETCH || phase == P_MEMREAD || phase == P_MEMWRITE) && !mem_ready) begin
      waitCnt++;
      if (waitCnt >= 15) modelBusErr = 1'b1;
    end else begin
      waitCnt = 0;
    end
  endtask

  // Entered and left at a falling edge.
  task automatic cycle(input string tag, input int phase, input logic rdy);
    mem_ready = rdy;
    #1;
    checkOutput(tag, phase);
    @(negedge clk);
  endtask

  task automatic waitPhase(input string tag, input int phase, input int delay);
    for (int i = 0; i < delay; i++) cycle(tag, phase, 1'b0);
    cycle(tag, phase, 1'b1);
  endtask

  task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input logic z, input int fetchDelay, input int memDelay);
    op = o; funct3 = f3; funct7b5 = f7; zero = z;
    waitPhase("fetch", P_FETCH, fetchDelay);
    cycle("decode", P_DECODE, 1'($urandom_range(0, 1)));
    case (o)
      OP_LW: begin
        cycle("memadr", P_MEMADR, 1'($urandom_range(0, 1)));
        waitPhase("memread", P_MEMREAD, memDelay);
        cycle("memwb", P_MEMWB, 1'($urandom_range(0, 1)));
        modelRetire++;
      end
      OP_SW: begin
        cycle("memadr", P_MEMADR, 1'($urandom_range(0, 1)));
        waitPhase("memwrite", P_MEMWRITE, memDelay);
        modelRetire++;
      end
      OP_R: begin
        cycle("execr", P_EXECR, 1'($urandom_range(0, 1)));
        cycle("aluwb", P_ALUWB, 1'($urandom_range(0, 1)));
        modelRetire++;
      end
      OP_I: begin
        cycle("execi", P_EXECI, 1'($urandom_range(0, 1)));
        cycle("aluwb", P_ALUWB, 1'($urandom_range(0, 1)));
        modelRetire++;
      end
      OP_BEQ: begin
        cycle("beq", P_BEQ, 1'($urandom_range(0, 1)));
        modelRetire++;
      end
      OP_JAL: begin
        cycle("jal", P_JAL, 1'($urandom_range(0, 1)));
        cycle("aluwb", P_ALUWB, 1'($urandom_range(0, 1)));
        modelRetire++;
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [6:0] legal [6];
    legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    srst = 1'b0; mem_ready = 1'b1; op = OP_R; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    #2;
    checkEq("reset_state", 32'(state_o), 32'h0);
    checkEq("reset_retire", retire_cnt, 32'h0);
    checkEq("reset_buserr", 32'(bus_err), 32'h0);
    checkEq("reset_illegal", 32'(illegal_instr), 32'h0);
    checkEq("reset_pcwrite", 32'(pc_write), 32'h0);
    checkEq("reset_irwrite", 32'(ir_write), 32'h0);
    checkEq("reset_memw", 32'(mem_w), 32'h0);
    checkEq("reset_regw", 32'(reg_w), 32'h0);
    @(negedge clk);
    @(negedge clk);
    srst = 1'b1;

    applyStimulus(OP_R, 3'b000, 1'b0, 1'b0, 0, 0);
    checkEq("add_retired", retire_cnt, 32'h1);
    applyStimulus(OP_R, 3'b000, 1'b1, 1'b0, 0, 0);
    applyStimulus(OP_SW, 3'b010, 1'b0, 1'b0, 0, 3);
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 1'b1, 0, 0);
    applyStimulus(OP_BEQ, 3'b000, 1'b0, 1'b0, 0, 0);
    applyStimulus(OP_LW, 3'b010, 1'b0, 1'b0, 2, 2);
    applyStimulus(OP_JAL, 3'b000, 1'b0, 1'b0, 1, 0);
    applyStimulus(OP_I, 3'b000, 1'b1, 1'b0, 0, 0);

    for (int n = 0; n < 40; n++)
      applyStimulus(legal[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    applyStimulus(OP_R, 3'b111, 1'b0, 1'b0, 16, 0);
    checkEq("timeout_sticky", 32'(bus_err), 32'h1);

    op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    cycle("rst_fetch", P_FETCH, 1'b1);
    cycle("rst_decode", P_DECODE, 1'b0);
    cycle("rst_memadr", P_MEMADR, 1'b0);
    mem_ready = 1'b0;
    #1;
    checkOutput("rst_memwrite", P_MEMWRITE);
    srst = 1'b0;
    #1;
    checkEq("rst_memw", 32'(mem_w), 32'h0);
    checkEq("rst_state", 32'(state_o), 32'h0);
    checkEq("rst_retire", retire_cnt, 32'h0);
    checkEq("rst_buserr", 32'(bus_err), 32'h0);
    modelRetire = '0; modelBusErr = 1'b0; waitCnt = 0;
    @(negedge clk);
    srst = 1'b1;

    op = 7'h7F; funct3 = 3'b000;
    cycle("ill_fetch", P_FETCH, 1'b1);
    cycle("ill_decode", P_DECODE, 1'b0);
`ifdef ILLEGAL_TRAP_EN
    modelIllegal = 1'b1;
    for (int k = 0; k < 4; k++) cycle("trap", P_TRAP, 1'($urandom_range(0, 1)));
`else
    cycle("nop_fetch", P_FETCH, 1'b1);
    cycle("nop_decode", P_DECODE, 1'b0);
    applyStimulus(OP_R, 3'b110, 1'b0, 1'b0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
